// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared constants and helpers for the data memory slice.
//   DM_WORDS  - default word depth of the data memory
//   DM_ADR_W  - default word-index width, clog2(DM_WORDS)
//   wlen_e    - store length encoding (bytes to write minus one)
//   be_to_mask- expands a 4-bit lane enable into a 32-bit bit mask
package data_memory_pkg;

  localparam int unsigned DM_WORDS = 1024;
  localparam int unsigned DM_ADR_W = 10;

  typedef enum logic [1:0] {
    WLEN_1B = 2'b00,
    WLEN_2B = 2'b01,
    WLEN_3B = 2'b10,
    WLEN_4B = 2'b11
  } wlen_e;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{be[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/data_memory_byteen.sv
// dm_byteen: byte-lane enable generator for stores (and future load merge).
//   lane [1:0] in  - starting byte lane, Adr[1:0]
//   wlen [1:0] in  - bytes to cover minus one
//   be   [3:0] out - lane k set iff lane <= k <= lane+wlen; runs past
//                    lane 3 are clipped, never wrapped to lane 0
module dm_byteen (
  input  logic [1:0] lane,
  input  logic [1:0] wlen,
  output logic [3:0] be
);

  // 3-bit sum so an overrun past lane 3 cannot wrap back to low lanes.
  logic [2:0] last;
  assign last = {1'b0, lane} + {1'b0, wlen};

  always_comb begin
    be = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      be[k] = (3'(k) >= {1'b0, lane}) && (3'(k) <= last);
    end
  end

endmodule

// File: rtl/data_memory.sv
// data_memory: data memory of the single-cycle MIPS datapath.
//   clk   in      clock, all state updates on posedge
//   reset in      synchronous active-high, clears the whole array
//   WE    in      store enable
//   Adr   in  32  byte address (word index Adr[ADR_W+1:2])
//   WData in  32  store data already positioned in its byte lanes
//   WLen  in   2  bytes to write minus one, starting at lane Adr[1:0]
//   PC    in  32  PC of the storing instruction, used only by the trace
//   RData out 32  full word at the addressed index, combinational;
//                 zero when the address is beyond the array
// Writes are byte-lane masked; each committed write prints one trace line
// showing the full post-write word.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned DM_WORDS = data_memory_pkg::DM_WORDS,
  parameter int unsigned ADR_W    = data_memory_pkg::DM_ADR_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] Adr,
  input  logic [31:0] WData,
  input  logic [1:0]  WLen,
  input  logic [31:0] PC,
  output logic [31:0] RData
);

  logic [31:0]      mem [DM_WORDS];
  logic [ADR_W-1:0] idx;
  logic             in_range;
  logic [3:0]       be;
  logic [31:0]      mask;
  logic [31:0]      merged;
  logic             commit;

  assign idx      = Adr[ADR_W+1:2];
  assign in_range = (Adr >> (ADR_W + 2)) == 32'd0;

  dm_byteen u_byteen (
    .lane (Adr[1:0]),
    .wlen (WLen),
    .be   (be)
  );

  assign mask   = be_to_mask(be);
  // Mask both operands so unselected lanes of WData never reach the array.
  assign merged = (mem[idx] & ~mask) | (WData & mask);
  assign commit = !reset && WE && in_range;

  assign RData = in_range ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) begin
        mem[ADR_W'(i)] <= '0;
      end
    end else if (commit) begin
      mem[idx] <= merged;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (commit) begin
      $display("%d@%h: *%h <= %h", $time, PC, {Adr[31:2], 2'b00}, merged);
    end
  end
`endif

endmodule
